// File: rtl/mul_seq_ctrl.sv
// Sequencer for an external 32x32 multiplier: drives both operands over the shared Z bus,
// pulses start, waits for done with a hang timeout, and holds the product for the consumer.
module mul_seq_ctrl #(
  parameter int unsigned TIMEOUT = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        in_ready,
  output logic [31:0] z_out,
  output logic        z_oe,
  output logic        mul_start,
  input  logic        mul_done,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        res_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    StIdle,
    StDrvA,
    StDrvB,
    StStart,
    StWait,
    StResp
  } state_e;

  localparam logic [7:0] TimeoutCnt  = 8'(TIMEOUT);
  localparam logic [7:0] LastWaitCnt = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [31:0] b_q;
  logic [31:0] z_out_q;
  logic [31:0] res_hi_q;
  logic [31:0] res_lo_q;
  logic        in_ready_q;
  logic        z_oe_q;
  logic        mul_start_q;
  logic        res_valid_q;
  logic        res_err_q;
  logic        busy_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      b_q         <= 32'd0;
      z_out_q     <= 32'd0;
      res_hi_q    <= 32'd0;
      res_lo_q    <= 32'd0;
      res_err_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      z_oe_q      <= 1'b0;
      mul_start_q <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            // z_out_q doubles as the latched multiplicand
            z_out_q    <= in_a;
            b_q        <= in_b;
            z_oe_q     <= 1'b1;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= StDrvA;
          end
        end
        StDrvA: begin
          z_out_q <= b_q;
          state_q <= StDrvB;
        end
        StDrvB: begin
          z_out_q     <= 32'd0;
          z_oe_q      <= 1'b0;
          mul_start_q <= 1'b1;
          state_q     <= StStart;
        end
        StStart: begin
          mul_start_q <= 1'b0;
          cnt_q       <= 8'd0;
          state_q     <= StWait;
        end
        StWait: begin
          // The edge that would bring the count to TIMEOUT ends the wait; done still wins there.
          if (mul_done) begin
            res_hi_q    <= mul_hi;
            res_lo_q    <= mul_lo;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b1;
            state_q     <= StResp;
          end else if (cnt_q >= LastWaitCnt) begin
            cnt_q       <= TimeoutCnt;
            res_hi_q    <= 32'd0;
            res_lo_q    <= 32'd0;
            res_err_q   <= 1'b1;
            res_valid_q <= 1'b1;
            state_q     <= StResp;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StResp: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q & rst;
  assign z_out     = z_out_q;
  assign z_oe      = z_oe_q;
  assign mul_start = mul_start_q;
  assign res_valid = res_valid_q;
  assign res_hi    = res_hi_q;
  assign res_lo    = res_lo_q;
  assign res_err   = res_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scenario bench for mul_seq_ctrl; expected results are queued when stimulus is driven and
// popped when the DUT presents res_valid.
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_ready;
  logic [31:0] z_out;
  logic        z_oe;
  logic        mul_start;
  logic        mul_done = 1'b0;
  logic [31:0] mul_hi = '0;
  logic [31:0] mul_lo = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_err;
  logic        busy;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
  } res_t;

  res_t sb[$];
  res_t e;
  int   pass_cnt = 0;
  int   total = 0;
  int   start_pulses = 0;

  mul_seq_ctrl #(.TIMEOUT(127)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ready  (in_ready),
    .z_out     (z_out),
    .z_oe      (z_oe),
    .mul_start (mul_start),
    .mul_done  (mul_done),
    .mul_hi    (mul_hi),
    .mul_lo    (mul_lo),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_hi    (res_hi),
    .res_lo    (res_lo),
    .res_err   (res_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mul_start) start_pulses++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Waits (bounded) for in_ready, then performs one accept; returns at the DRV_A negedge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Returns at the negedge inside the first WAIT cycle.
  task automatic run_to_wait(input logic [31:0] a, input logic [31:0] b);
    start_op(a, b);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    total++;
    if ({in_ready, busy, z_oe, z_out, mul_start, res_valid, res_hi, res_lo, res_err} !== '0)
      $display("FAIL reset_outputs got rdy=%0b busy=%0b oe=%0b z=%h st=%0b v=%0b hi=%h lo=%h err=%0b exp all 0",
               in_ready, busy, z_oe, z_out, mul_start, res_valid, res_hi, res_lo, res_err);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_ready got %0b exp 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_single();
    start_pulses = 0;
    start_op(32'd3, 32'd5);
    total++;
    if ({z_oe, z_out, busy, in_ready} !== {1'b1, 32'd3, 1'b1, 1'b0})
      $display("FAIL single_drv_a got oe=%0b z=%h busy=%0b rdy=%0b exp oe=1 z=3 busy=1 rdy=0",
               z_oe, z_out, busy, in_ready);
    else pass_cnt++;
    tick();
    total++;
    if ({z_oe, z_out, mul_start} !== {1'b1, 32'd5, 1'b0})
      $display("FAIL single_drv_b got oe=%0b z=%h st=%0b exp oe=1 z=5 st=0", z_oe, z_out, mul_start);
    else pass_cnt++;
    tick();
    total++;
    if ({z_oe, z_out, mul_start} !== {1'b0, 32'd0, 1'b1})
      $display("FAIL single_start got oe=%0b z=%h st=%0b exp oe=0 z=0 st=1", z_oe, z_out, mul_start);
    else pass_cnt++;
    tick();
    repeat (10) tick();
    total++;
    if (res_valid !== 1'b0) $display("FAIL single_early_valid got %0b exp 0", res_valid);
    else pass_cnt++;
    mul_done = 1'b1;
    mul_hi   = 32'd0;
    mul_lo   = 32'd15;
    sb.push_back('{hi: 32'd0, lo: 32'd15, err: 1'b0});
    tick();
    mul_done = 1'b0;
    e = sb.pop_front();
    total++;
    if ({res_valid, res_hi, res_lo, res_err} !== {1'b1, e})
      $display("FAIL single_result got v=%0b hi=%h lo=%h err=%0b exp v=1 hi=%h lo=%h err=%0b",
               res_valid, res_hi, res_lo, res_err, e.hi, e.lo, e.err);
    else pass_cnt++;
    tick();
    total++;
    if ({res_valid, busy, in_ready} !== 3'b001 || start_pulses !== 1)
      $display("FAIL single_idle got v=%0b busy=%0b rdy=%0b pulses=%0d exp v=0 busy=0 rdy=1 pulses=1",
               res_valid, busy, in_ready, start_pulses);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    run_to_wait(32'd7, 32'd9);
    res_ready = 1'b0;
    mul_done  = 1'b1;
    mul_hi    = 32'h0000_0001;
    mul_lo    = 32'h0000_0002;
    sb.push_back('{hi: 32'h1, lo: 32'h2, err: 1'b0});
    tick();
    mul_done = 1'b0;
    e = sb.pop_front();
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({res_valid, in_ready, busy, res_hi, res_lo, res_err} !== {3'b101, e})
        $display("FAIL bp_hold_%0d got v=%0b rdy=%0b busy=%0b hi=%h lo=%h err=%0b exp v=1 rdy=0 busy=1 hi=%h lo=%h err=%0b",
                 i, res_valid, in_ready, busy, res_hi, res_lo, res_err, e.hi, e.lo, e.err);
      else pass_cnt++;
      mul_hi   = $urandom;
      mul_lo   = $urandom;
      mul_done = (i % 2 == 0);
      tick();
    end
    mul_done  = 1'b0;
    res_ready = 1'b1;
    total++;
    if ({res_valid, res_hi, res_lo, res_err} !== {1'b1, e})
      $display("FAIL bp_release got v=%0b hi=%h lo=%h err=%0b exp v=1 hi=%h lo=%h err=%0b",
               res_valid, res_hi, res_lo, res_err, e.hi, e.lo, e.err);
    else pass_cnt++;
    tick();
    total++;
    if ({res_valid, busy, in_ready} !== 3'b001)
      $display("FAIL bp_idle got v=%0b busy=%0b rdy=%0b exp v=0 busy=0 rdy=1", res_valid, busy, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    mul_hi = 32'hDEAD_BEEF;
    mul_lo = 32'hCAFE_F00D;
    run_to_wait(32'd1, 32'd2);
    sb.push_back('{hi: 32'd0, lo: 32'd0, err: 1'b1});
    repeat (126) tick();
    total++;
    if ({res_valid, busy} !== 2'b01)
      $display("FAIL timeout_early got v=%0b busy=%0b exp v=0 busy=1", res_valid, busy);
    else pass_cnt++;
    tick();
    e = sb.pop_front();
    total++;
    if ({res_valid, res_hi, res_lo, res_err} !== {1'b1, e})
      $display("FAIL timeout_result got v=%0b hi=%h lo=%h err=%0b exp v=1 hi=%h lo=%h err=%0b",
               res_valid, res_hi, res_lo, res_err, e.hi, e.lo, e.err);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_tie();
    run_to_wait(32'd11, 32'd13);
    repeat (126) tick();
    total++;
    if (res_valid !== 1'b0) $display("FAIL tie_early got %0b exp 0", res_valid);
    else pass_cnt++;
    mul_done = 1'b1;
    mul_hi   = 32'h0000_1234;
    mul_lo   = 32'hFFFF_FFFF;
    sb.push_back('{hi: 32'h1234, lo: 32'hFFFF_FFFF, err: 1'b0});
    tick();
    mul_done = 1'b0;
    e = sb.pop_front();
    total++;
    if ({res_valid, res_hi, res_lo, res_err} !== {1'b1, e})
      $display("FAIL tie_result got v=%0b hi=%h lo=%h err=%0b exp v=1 hi=%h lo=%h err=%0b",
               res_valid, res_hi, res_lo, res_err, e.hi, e.lo, e.err);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_wait();
    run_to_wait(32'd4, 32'd6);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    total++;
    if ({in_ready, busy, z_oe, z_out, mul_start, res_valid, res_hi, res_lo, res_err} !== '0)
      $display("FAIL rstwait_outputs got rdy=%0b busy=%0b oe=%0b z=%h st=%0b v=%0b hi=%h lo=%h err=%0b exp all 0",
               in_ready, busy, z_oe, z_out, mul_start, res_valid, res_hi, res_lo, res_err);
    else pass_cnt++;
    rst      = 1'b1;
    mul_done = 1'b1;
    mul_lo   = 32'd99;
    repeat (2) tick();
    mul_done = 1'b0;
    total++;
    if ({res_valid, busy, in_ready, res_lo} !== {3'b001, 32'd0})
      $display("FAIL rstwait_late_done got v=%0b busy=%0b rdy=%0b lo=%h exp v=0 busy=0 rdy=1 lo=0",
               res_valid, busy, in_ready, res_lo);
    else pass_cnt++;
    run_to_wait(32'd6, 32'd7);
    repeat (2) tick();
    mul_done = 1'b1;
    mul_hi   = 32'd0;
    mul_lo   = 32'd42;
    sb.push_back('{hi: 32'd0, lo: 32'd42, err: 1'b0});
    tick();
    mul_done = 1'b0;
    e = sb.pop_front();
    total++;
    if ({res_valid, res_hi, res_lo, res_err} !== {1'b1, e})
      $display("FAIL rstwait_next_op got v=%0b hi=%h lo=%h err=%0b exp v=1 hi=%h lo=%h err=%0b",
               res_valid, res_hi, res_lo, res_err, e.hi, e.lo, e.err);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_stray_done();
    mul_done = 1'b1;
    mul_lo   = 32'd77;
    tick();
    mul_done = 1'b0;
    total++;
    if ({res_valid, busy, in_ready} !== 3'b001)
      $display("FAIL stray_idle got v=%0b busy=%0b rdy=%0b exp v=0 busy=0 rdy=1", res_valid, busy, in_ready);
    else pass_cnt++;
    start_op(32'd8, 32'd9);
    tick();
    mul_done = 1'b1;
    tick();
    mul_done = 1'b0;
    total++;
    if ({mul_start, res_valid, z_oe} !== 3'b100)
      $display("FAIL stray_drv_b got st=%0b v=%0b oe=%0b exp st=1 v=0 oe=0", mul_start, res_valid, z_oe);
    else pass_cnt++;
    tick();
    tick();
    mul_done = 1'b1;
    mul_hi   = 32'd0;
    mul_lo   = 32'd72;
    sb.push_back('{hi: 32'd0, lo: 32'd72, err: 1'b0});
    tick();
    mul_done = 1'b0;
    e = sb.pop_front();
    total++;
    if ({res_valid, res_hi, res_lo, res_err} !== {1'b1, e})
      $display("FAIL stray_result got v=%0b hi=%h lo=%h err=%0b exp v=1 hi=%h lo=%h err=%0b",
               res_valid, res_hi, res_lo, res_err, e.hi, e.lo, e.err);
    else pass_cnt++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_timeout();
    test_tie();
    test_reset_wait();
    test_stray_done();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
